// File: rtl/chan_sched_rr.sv
// Round-robin channel scheduler feeding the 3-to-8 decoder: dwell-timed grants separated by a one-cycle guard gap.
// Optional build macro CHSCHED_LOCK_EN adds lock_i, which holds a grant past dwell expiry.
module chan_sched_rr #(
  parameter int DWELL   = 16,
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         req,
`ifdef CHSCHED_LOCK_EN
  input  logic               lock_i,
`endif
  input  logic               release_i,
  output logic [2:0]         sel,
  output logic               sel_valid,
  output logic               grant_start,
  output logic [DWELL_W-1:0] dwell_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_GAP
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [2:0]           r_sel, w_sel_nxt;
  logic [2:0]           r_last, w_last_nxt;
  logic [DWELL_W-1:0]   r_dwell, w_dwell_nxt;
  logic                 r_start, w_start_nxt;
  logic                 w_found;
  logic [2:0]           w_win;
  logic                 w_lock;
  logic                 w_end;

`ifdef CHSCHED_LOCK_EN
  assign w_lock = lock_i;
`else
  assign w_lock = 1'b0;
`endif

  // Search from last+1 upward; the 3-bit add wraps modulo 8, offset 8 lands back on last.
  always_comb begin : arb
    logic [2:0] idx;
    w_found = 1'b0;
    w_win   = '0;
    idx     = '0;
    for (int unsigned i = 1; i <= 8; i++) begin
      idx = r_last + 3'(i);
      if (!w_found && req[idx]) begin
        w_found = 1'b1;
        w_win   = idx;
      end
    end
  end

  assign w_end = ((r_dwell == '0) && !w_lock) || release_i || !req[r_sel];

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_last_nxt  = r_last;
    w_dwell_nxt = r_dwell;
    w_start_nxt = 1'b0;
    case (r_state)
      ST_GRANT: begin
        if (w_end) begin
          w_state_nxt = ST_GAP;
          w_dwell_nxt = '0;
        end else if (r_dwell != '0) begin
          w_dwell_nxt = r_dwell - DWELL_W'(1);
        end
      end
      default: begin
        // IDLE and GAP arbitrate identically; sel holds through GAP so the decoder input stays put.
        if (w_found) begin
          w_state_nxt = ST_GRANT;
          w_sel_nxt   = w_win;
          w_last_nxt  = w_win;
          w_dwell_nxt = DWELL_W'(DWELL - 1);
          w_start_nxt = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
          w_dwell_nxt = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_sel   <= '0;
      r_last  <= 3'd7;
      r_dwell <= '0;
      r_start <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_last  <= w_last_nxt;
      r_dwell <= w_dwell_nxt;
      r_start <= w_start_nxt;
    end
  end

  assign sel         = r_sel;
  assign sel_valid   = (r_state == ST_GRANT);
  assign grant_start = r_start;
  assign dwell_cnt   = r_dwell;

endmodule
